param_extend_pipe: RTL and testbench
====================================

Name: param_extend_pipe

Overview:
- Multi-channel sign/width conversion stage with a valid/ready handshake.
- Converts each IN_W-bit lane value to OUT_W bits by sign-extension, zero-extension or truncation, choosing signedness per channel from the source flag or a forcing mode.
- Buffers results in a DEPTH-entry output FIFO, reports a per-lane sign-check bit and truncation loss, and keeps a saturating loss counter.
- Sits between parameter/constant-evaluation logic and the cosim output packer. It generalises fixed-width signedness checks to runtime, multi-lane, pipelined conversion.

Parameters:
- NCH, 4, number of lanes.
- IN_W, 8, source lane width (>=1).
- OUT_W, 16, destination lane width (>=1; may be less than, equal to or greater than IN_W).
- DEPTH, 2, output FIFO entries (>=1).
- CNT_W, 8, width of the truncation-event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  NCH*IN_W  lane i is bits [i*IN_W +: IN_W].
- in_src_signed  in  NCH  source literal signedness per lane.
- mode  in  2*NCH  per lane: 0 inherit, 1 force signed, 2 force unsigned, 3 reserved.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  NCH*OUT_W  converted lanes.
- out_sign  out  NCH  bit OUT_W of the lane's (OUT_W+1)-bit extension.
- out_trunc  out  NCH  lane lost information.
- trunc_count  out  CNT_W  saturating count of accepted lanes with trunc=1.
- cnt_clr  in  1  synchronous clear of trunc_count.
- cfg_err  out  1  sticky: an accepted beat had mode==3 on some lane.

Behaviour:
- Reset: while rst_n is low, asynchronously FIFO empty, out_valid=0, out_data=0, out_sign=0, out_trunc=0, trunc_count=0, cfg_err=0. in_ready=1 from the first cycle after reset.
- Effective signedness per lane: mode 0 -> in_src_signed[i]; 1 -> signed; 2 -> unsigned; 3 -> unsigned and sets cfg_err. The declared type always overrides the source flag.
- Conversion when OUT_W>IN_W: replicate the MSB if signed, else pad with zeros.
- Conversion when OUT_W==IN_W: copy.
- Conversion when OUT_W<IN_W: keep the low OUT_W bits.
  - Signed: trunc=1 if any dropped bit differs from out bit OUT_W-1.
  - Unsigned: trunc=1 if any dropped bit is 1.
  - When OUT_W>=IN_W, trunc=0.
- out_sign = effective_signed ? out bit OUT_W-1 : 0.
- Handshake and FIFO:
  - Conversion is combinational on in_data; the converted beat is pushed into the FIFO on accept.
  - in_ready = !full. There is no combinational path from out_ready to in_ready.
  - Latency: a beat accepted at edge t with the FIFO empty gives out_valid=1 from edge t. The head is registered and visible in the cycle after the accepting edge.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop when not full: occupancy unchanged, order preserved.
  - When full, push is blocked even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH. Output data holds stable while out_valid && !out_ready.
- trunc_count:
  - On each accept, add popcount(trunc lanes) and saturate at 2^CNT_W-1.
  - cnt_clr has priority: the count becomes 0 and that beat's contribution is dropped.
- Reset mid-operation: all buffered beats are discarded and no partial beat is emitted.

Decomposition:
- Package param_ext_pkg: mode enum (EXT_INHERIT, EXT_SIGNED, EXT_UNSIGNED, EXT_RSVD) and a lane_result_t struct {data, sign, trunc}.
- Sub-module ext_lane: purely combinational, per-lane conversion. Inputs are value, src_signed and mode; outputs are data, sign, trunc and rsvd.
- Instantiate ext_lane NCH times via generate. FIFO, counter and cfg_err stay in the top.

Test Plan:
- OUT_W=16, lane 0=8'hA8, src_signed=0, mode=0 -> out 16'h00A8, sign=0, trunc=0. Same with mode=1 -> 16'hFFA8, sign=1.
- src_signed=1, lane=8'hA8, mode=2 -> 16'h00A8, sign=0. The forced unsigned declared type overrides the signed source.
- Instance OUT_W=4:
  - 8'hA8 unsigned -> 4'h8, trunc=1, trunc_count +1.
  - 8'hF8 signed -> 4'h8, trunc=0.
  - 8'h78 signed -> 4'h8, trunc=1.
- DEPTH=2, out_ready=0, send 3 beats -> in_ready drops after the 2nd accept. Raising out_ready drains beats 1, 2, 3 in order with stable data while stalled.
- CNT_W=2, four beats each with 1 truncating lane -> trunc_count saturates at 3. A cnt_clr pulse on a truncating beat -> 0.
- Assert rst_n low with 2 beats buffered, mid-cycle -> out_valid=0 immediately. After release, FIFO is empty and cfg_err=0. A mode=3 beat then sets cfg_err=1, held until reset.

Source files
------------

// File: rtl/param_extend_pipe_pkg.sv
// Shared types for the lane width/sign conversion pipe.
//   ext_mode_e    : per-lane signedness selection (inherit / force signed / force unsigned / reserved)
//   lane_result_t : one converted lane, carried at EXT_MAX_W bits so the sub-module can
//                   derive the truncation flag from the bits above OUT_W
package param_ext_pkg;

    typedef enum logic [1:0] {
        EXT_INHERIT  = 2'd0,
        EXT_SIGNED   = 2'd1,
        EXT_UNSIGNED = 2'd2,
        EXT_RSVD     = 2'd3
    } ext_mode_e;

    // Internal extension width; IN_W and OUT_W must both be strictly below this.
    localparam int unsigned EXT_MAX_W = 64;

    typedef struct packed {
        logic [EXT_MAX_W-1:0] data;
        logic                 sign;
        logic                 trunc;
    } lane_result_t;

endpackage

// File: rtl/param_extend_pipe_ext_lane.sv
// Combinational conversion of one lane from IN_W to OUT_W bits.
// Ports:
//   value      : IN_W-bit source lane
//   src_signed : signedness carried by the source literal
//   mode       : declared-type override (ext_mode_e)
//   data       : OUT_W-bit converted value
//   sign       : effective_signed ? data[OUT_W-1] : 0
//   trunc      : conversion lost information
//   rsvd       : mode is the reserved encoding
module ext_lane
    import param_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic [IN_W-1:0]  value,
    input  logic             src_signed,
    input  ext_mode_e        mode,
    output logic [OUT_W-1:0] data,
    output logic             sign,
    output logic             trunc,
    output logic             rsvd
);

    logic                       eff_signed;
    lane_result_t               res;
    logic [EXT_MAX_W-OUT_W-1:0] dropped;

    always_comb begin
        eff_signed = 1'b0;
        rsvd       = 1'b0;
        unique case (mode)
            EXT_INHERIT:  eff_signed = src_signed;
            EXT_SIGNED:   eff_signed = 1'b1;
            EXT_UNSIGNED: eff_signed = 1'b0;
            EXT_RSVD: begin
                eff_signed = 1'b0;
                rsvd       = 1'b1;
            end
        endcase
    end

    // Extend to the full internal width first; everything above OUT_W is then exactly the
    // set of dropped bits (plus copies of the source MSB), which covers all three
    // OUT_W vs IN_W cases with one comparison.
    always_comb begin
        res = '0;
        if (eff_signed) begin
            res.data = {{(EXT_MAX_W-IN_W){value[IN_W-1]}}, value};
        end else begin
            res.data = {{(EXT_MAX_W-IN_W){1'b0}}, value};
        end
        dropped  = res.data[EXT_MAX_W-1:OUT_W];
        res.sign = eff_signed & res.data[OUT_W-1];
        if (eff_signed) begin
            res.trunc = |(dropped ^ {(EXT_MAX_W-OUT_W){res.data[OUT_W-1]}});
        end else begin
            res.trunc = |dropped;
        end
    end

    assign data  = res.data[OUT_W-1:0];
    assign sign  = res.sign;
    assign trunc = res.trunc;

endmodule

// File: rtl/param_extend_pipe.sv
// Multi-lane sign/width conversion stage with a DEPTH-entry output FIFO.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : input handshake; in_ready = FIFO not full
//   in_data                : NCH lanes of IN_W bits, lane i at [i*IN_W +: IN_W]
//   in_src_signed          : per-lane source signedness
//   mode                   : per-lane 2-bit ext_mode_e
//   out_valid/out_ready    : output handshake on the registered FIFO head
//   out_data/out_sign/out_trunc : converted lanes and per-lane flags of the head beat
//   trunc_count, cnt_clr   : saturating count of truncating lanes, synchronous clear
//   cfg_err                : sticky, an accepted beat used the reserved mode
module param_extend_pipe
    import param_ext_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*IN_W-1:0]  in_data,
    input  logic [NCH-1:0]       in_src_signed,
    input  logic [2*NCH-1:0]     mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*OUT_W-1:0] out_data,
    output logic [NCH-1:0]       out_sign,
    output logic [NCH-1:0]       out_trunc,
    output logic [CNT_W-1:0]     trunc_count,
    input  logic                 cnt_clr,
    output logic                 cfg_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned PC_W  = $clog2(NCH + 1);
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NCH*OUT_W-1:0] lane_data;
    logic [NCH-1:0]       lane_sign;
    logic [NCH-1:0]       lane_trunc;
    logic [NCH-1:0]       lane_rsvd;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        ext_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .value      (in_data[i*IN_W +: IN_W]),
            .src_signed (in_src_signed[i]),
            .mode       (ext_mode_e'(mode[2*i +: 2])),
            .data       (lane_data[i*OUT_W +: OUT_W]),
            .sign       (lane_sign[i]),
            .trunc      (lane_trunc[i]),
            .rsvd       (lane_rsvd[i])
        );
    end

    // FIFO storage and control
    logic [NCH*OUT_W-1:0] data_mem_q  [DEPTH];
    logic [NCH-1:0]       sign_mem_q  [DEPTH];
    logic [NCH-1:0]       trunc_mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]     count_q;
    logic                 push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // in_ready depends only on occupancy, never on out_ready.
    assign in_ready  = (count_q != OCC_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_data  = data_mem_q[rd_ptr_q];
    assign out_sign  = sign_mem_q[rd_ptr_q];
    assign out_trunc = trunc_mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i]  <= '0;
                sign_mem_q[i]  <= '0;
                trunc_mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                data_mem_q[wr_ptr_q]  <= lane_data;
                sign_mem_q[wr_ptr_q]  <= lane_sign;
                trunc_mem_q[wr_ptr_q] <= lane_trunc;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + OCC_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - OCC_W'(1);
            end
        end
    end

    // Truncation counter
    logic [PC_W-1:0]  trunc_pop;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] trunc_count_q;
    logic             cfg_err_q;

    always_comb begin
        trunc_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            trunc_pop = trunc_pop + PC_W'(lane_trunc[i]);
        end
        cnt_sum = SUM_W'(trunc_count_q) + SUM_W'(trunc_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trunc_count_q <= '0;
            cfg_err_q     <= 1'b0;
        end else begin
            // Clear wins over the accepted beat's contribution.
            if (cnt_clr) begin
                trunc_count_q <= '0;
            end else if (push) begin
                trunc_count_q <= (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
            end
            if (push && (|lane_rsvd)) begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    assign trunc_count = trunc_count_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_param_extend_pipe.sv
// Directed bench: a widening instance (OUT_W=16) and a narrowing instance (OUT_W=4,
// CNT_W=2) share the same stimulus; both use NCH=4, IN_W=8, DEPTH=2.
module tb_param_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_src_signed;
    logic [7:0]  mode;
    logic        out_ready;
    logic        cnt_clr;

    logic        w_in_ready, w_out_valid, w_cfg_err;
    logic [63:0] w_out_data;
    logic [3:0]  w_out_sign, w_out_trunc;
    logic [7:0]  w_trunc_count;

    logic        n_in_ready, n_out_valid, n_cfg_err;
    logic [15:0] n_out_data;
    logic [3:0]  n_out_sign, n_out_trunc;
    logic [1:0]  n_trunc_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    param_extend_pipe #(
        .NCH   (4),
        .IN_W  (8),
        .OUT_W (16),
        .DEPTH (2),
        .CNT_W (8)
    ) dut_w (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (w_in_ready),
        .in_data       (in_data),
        .in_src_signed (in_src_signed),
        .mode          (mode),
        .out_valid     (w_out_valid),
        .out_ready     (out_ready),
        .out_data      (w_out_data),
        .out_sign      (w_out_sign),
        .out_trunc     (w_out_trunc),
        .trunc_count   (w_trunc_count),
        .cnt_clr       (cnt_clr),
        .cfg_err       (w_cfg_err)
    );

    param_extend_pipe #(
        .NCH   (4),
        .IN_W  (8),
        .OUT_W (4),
        .DEPTH (2),
        .CNT_W (2)
    ) dut_n (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (n_in_ready),
        .in_data       (in_data),
        .in_src_signed (in_src_signed),
        .mode          (mode),
        .out_valid     (n_out_valid),
        .out_ready     (out_ready),
        .out_data      (n_out_data),
        .out_sign      (n_out_sign),
        .out_trunc     (n_out_trunc),
        .trunc_count   (n_trunc_count),
        .cnt_clr       (cnt_clr),
        .cfg_err       (n_cfg_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] s, input logic [7:0] m);
        in_valid      = 1'b1;
        in_data       = d;
        in_src_signed = s;
        mode          = m;
    endtask

    // One beat through an empty FIFO with out_ready=1: check the head, then let it pop.
    task automatic conv(input string tag, input logic [31:0] d, input logic [3:0] s,
                        input logic [7:0] m, input logic [63:0] w_data, input logic [3:0] w_sign,
                        input logic [15:0] n_data, input logic [3:0] n_sign,
                        input logic [3:0] n_trunc);
        drive(d, s, m);
        tick();
        in_valid = 1'b0;
        check({tag, ".w_valid"}, 64'(w_out_valid), 64'(1));
        check({tag, ".w_data"},  w_out_data, w_data);
        check({tag, ".w_sign"},  64'(w_out_sign), 64'(w_sign));
        check({tag, ".w_trunc"}, 64'(w_out_trunc), 64'(0));
        check({tag, ".n_data"},  64'(n_out_data), 64'(n_data));
        check({tag, ".n_sign"},  64'(n_out_sign), 64'(n_sign));
        check({tag, ".n_trunc"}, 64'(n_out_trunc), 64'(n_trunc));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        in_valid      = 1'b0;
        in_data       = '0;
        in_src_signed = '0;
        mode          = '0;
        out_ready     = 1'b1;
        cnt_clr       = 1'b0;

        // Reset state
        #3;
        check("rst.w_valid", 64'(w_out_valid), 64'(0));
        check("rst.n_valid", 64'(n_out_valid), 64'(0));
        check("rst.w_data",  w_out_data, 64'(0));
        check("rst.w_cnt",   64'(w_trunc_count), 64'(0));
        check("rst.cfg_err", 64'(w_cfg_err), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst.w_ready", 64'(w_in_ready), 64'(1));
        check("rst.n_ready", 64'(n_in_ready), 64'(1));

        // Lanes {3,2,1,0} = {00,7F,80,A8}
        conv("v1_inherit_uns", 32'h007F80A8, 4'b0000, 8'h00,
             64'h0000_007F_0080_00A8, 4'b0000, 16'h0F08, 4'b0000, 4'b0111);
        check("v1.n_cnt", 64'(n_trunc_count), 64'(3));
        check("v1.w_cnt", 64'(w_trunc_count), 64'(0));
        conv("v2_force_sgn", 32'h007F80A8, 4'b0000, 8'h55,
             64'h0000_007F_FF80_FFA8, 4'b0011, 16'h0F08, 4'b0101, 4'b0111);
        check("v2.n_cnt_sat", 64'(n_trunc_count), 64'(3));
        conv("v3_force_uns", 32'h007F80A8, 4'b1111, 8'hAA,
             64'h0000_007F_0080_00A8, 4'b0000, 16'h0F08, 4'b0000, 4'b0111);

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr.n_cnt", 64'(n_trunc_count), 64'(0));

        // Lane0 A8 unsigned, lane1 F8 signed (src), lane2 78 forced signed
        conv("v4_mixed", 32'h0078F8A8, 4'b0010, 8'h10,
             64'h0000_0078_FFF8_00A8, 4'b0010, 16'h0888, 4'b0110, 4'b0101);
        check("v4.n_cnt", 64'(n_trunc_count), 64'(2));
        conv("s1", 32'h000000A8, 4'b0000, 8'h00, 64'h00A8, 4'b0000, 16'h0008, 4'b0000, 4'b0001);
        check("s1.n_cnt", 64'(n_trunc_count), 64'(3));
        conv("s2", 32'h000000A8, 4'b0000, 8'h00, 64'h00A8, 4'b0000, 16'h0008, 4'b0000, 4'b0001);
        check("s2.n_cnt_sat", 64'(n_trunc_count), 64'(3));
        cnt_clr = 1'b1;
        conv("s3", 32'h000000A8, 4'b0000, 8'h00, 64'h00A8, 4'b0000, 16'h0008, 4'b0000, 4'b0001);
        cnt_clr = 1'b0;
        check("s3.n_cnt_clr", 64'(n_trunc_count), 64'(0));
        check("s3.w_cnt", 64'(w_trunc_count), 64'(0));

        // FIFO fill, stall and drain
        out_ready = 1'b0;
        drive(32'h01, 4'b0000, 8'h00);
        tick();
        check("f1.w_ready", 64'(w_in_ready), 64'(1));
        check("f1.w_head",  w_out_data, 64'h1);
        drive(32'h02, 4'b0000, 8'h00);
        tick();
        check("f2.w_ready_full", 64'(w_in_ready), 64'(0));
        check("f2.n_ready_full", 64'(n_in_ready), 64'(0));
        check("f2.w_head",       w_out_data, 64'h1);
        drive(32'h03, 4'b0000, 8'h00);
        tick();
        check("f3.stall_valid", 64'(w_out_valid), 64'(1));
        check("f3.stall_w_head", w_out_data, 64'h1);
        check("f3.stall_n_head", 64'(n_out_data), 64'h1);
        check("f3.blocked",     64'(w_in_ready), 64'(0));
        tick();
        check("f4.stall_w_head", w_out_data, 64'h1);
        out_ready = 1'b1;
        tick();
        check("f5.w_head2", w_out_data, 64'h2);
        check("f5.n_head2", 64'(n_out_data), 64'h2);
        check("f5.w_ready", 64'(w_in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        check("f6.w_head3", w_out_data, 64'h3);
        check("f6.w_valid", 64'(w_out_valid), 64'(1));
        tick();
        check("f7.w_empty", 64'(w_out_valid), 64'(0));
        check("f7.n_empty", 64'(n_out_valid), 64'(0));

        // Reset with two beats buffered, one of them using the reserved mode
        out_ready = 1'b0;
        drive(32'h05, 4'b0000, 8'h03);
        tick();
        drive(32'h06, 4'b0000, 8'h00);
        tick();
        in_valid = 1'b0;
        check("r0.cfg_err_set", 64'(w_cfg_err), 64'(1));
        check("r0.n_full",      64'(n_in_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check("r1.w_valid",   64'(w_out_valid), 64'(0));
        check("r1.n_valid",   64'(n_out_valid), 64'(0));
        check("r1.w_data",    w_out_data, 64'(0));
        check("r1.n_cfg_err", 64'(n_cfg_err), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("r2.w_valid",   64'(w_out_valid), 64'(0));
        check("r2.w_ready",   64'(w_in_ready), 64'(1));
        check("r2.w_cfg_err", 64'(w_cfg_err), 64'(0));

        out_ready = 1'b1;
        drive(32'h05, 4'b0000, 8'h03);
        tick();
        in_valid = 1'b0;
        check("r3.cfg_err",  64'(w_cfg_err), 64'(1));
        check("r3.n_cfg_err", 64'(n_cfg_err), 64'(1));
        check("r3.w_head",   w_out_data, 64'h5);
        tick();
        conv("r4_normal", 32'h05, 4'b0000, 8'h00, 64'h5, 4'b0000, 16'h0005, 4'b0000, 4'b0000);
        check("r4.cfg_err_held", 64'(w_cfg_err), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
